l0_loader: RTL
==============

# l0_loader

Sequencing controller for the L0 input buffer: a bank of `row` per-row FIFOs (depth 64) whose read enable is staggered one row per cycle internally.
- On `start` it streams `len` activation vectors from the activation SRAM into L0, then issues `len` read pulses to feed the systolic array.
- It then waits out the `row`-cycle skew so the last row has popped, and pulses `done`.
- It moves no data: SRAM `Q` connects straight to L0 `in`. It only drives SRAM control, L0 `wr`/`rd` and status.

## Interface
- `row`, 8, number of L0 rows (FIFOs); sets the flush length.
- `depth`, 64, L0 FIFO depth; `len` saturates to this value.
- `addr_w`, 11, SRAM address width.
- `len_w`, 7, width of `len` (must hold `depth`).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `base_addr`  in  addr_w  first SRAM address; sampled with `start`.
- `len`  in  len_w  number of vectors; sampled with `start`.
- `ex_en`  in  1  array may accept a vector this cycle; gates `l0_rd`.
- `l0_full`  in  1  OR of L0 FIFO full flags.
- `sram_cen`  out  1  SRAM chip enable, active-low.
- `sram_wen`  out  1  SRAM write enable, active-low; tied high (read-only).
- `sram_addr`  out  addr_w  SRAM read address.
- `l0_wr`  out  1  L0 write strobe; aligned with SRAM read data.
- `l0_rd`  out  1  L0 row-0 read request.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky overflow flag.

## Operation
- All outputs are registered.
- Reset values: `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `l0_wr`=0, `l0_rd`=0, `busy`=0, `done`=0, `err`=0. All state → IDLE and all counters clear.
- Reset mid-job aborts immediately. Nothing resumes after reset; L0 contents are the user's problem.
- Effective length: `n` = min(`len`, `depth`).
- States:
  - IDLE: `start`=1 latches `base_addr` and `n`. Go to LOAD if `n`>0, else to DONE.
  - LOAD: `sram_cen`=0 for `n` consecutive cycles, with `sram_addr` = `base_addr`+k (k=0..n-1). Address wraps modulo 2^addr_w. Go to LWAIT after the last read.
  - LWAIT: one cycle so the last write lands, then DRAIN.
  - DRAIN: `l0_rd`=1 in each cycle where `ex_en`=1, until `n` pulses are issued. While `ex_en`=0, `l0_rd`=0 and the state holds. Go to FLUSH after the n-th pulse.
  - FLUSH: exactly `row` cycles, a down-counter from row-1 to 0. Covers the internal rd stagger so row `row-1` completes its last pop. Then DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `l0_wr` is the 1-cycle-delayed copy of the LOAD read issue (SRAM latency 1), so exactly `n` write strobes occur.
- `err` is set when `l0_wr`=1 and `l0_full`=1 in the same cycle. It clears only on reset. The job continues regardless.
- `start` while `busy`=1 is ignored. `start` in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- `ex_en` has no effect outside DRAIN.

## Timing
- Cycle 0 is the edge that samples `start` in IDLE. Below, cycle t is the t-th edge after cycle 0.
- `sram_cen`=0 in cycles 1..n; `sram_addr`=base+t-1.
- `l0_wr`=1 in cycles 2..n+1.
- LWAIT is cycle n+1 (it overlaps the last write).
- With `ex_en` held high, `l0_rd`=1 in cycles n+2..2n+1. Each `ex_en`=0 cycle in DRAIN extends the job by one cycle.
- FLUSH occupies cycles 2n+2..2n+1+row.
- `done`=1 in cycle 2n+2+row. `busy`=1 in cycles 1..2n+2+row.
- Case n=0: `busy`=1 and `done`=1 in cycle 1 only. No SRAM or L0 activity.
- Earliest restart: `start` sampled in the cycle after `done`.

## Test plan
- Basic job, `base_addr`=0x010, `len`=4, row=8, `ex_en`=1:
  - reads 0x010..0x013 in cycles 1-4;
  - `l0_wr` in cycles 2-5, `l0_rd` in cycles 6-9;
  - `done` in cycle 18 only; `busy` in cycles 1-18; `err`=0.
- DRAIN stall, `len`=3, `ex_en` low in cycles 6-7:
  - `l0_rd` high in cycles 5, 8, 9;
  - FLUSH cycles 10-17; `done` in cycle 18.
- Length edge cases:
  - `len`=0 → `busy`/`done` in cycle 1 only; no `sram_cen` low, no `l0_wr`.
  - `len`=100 → exactly 64 reads and 64 `l0_rd` pulses.
- Address wrap, `base_addr`=0x7FE, `len`=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Overflow flag: force `l0_full`=1 in cycle 3 of a `len`=4 job → `err` rises in cycle 4 and stays 1. Job still completes with `done` in cycle 18. `err` clears only on `reset` low.
- Control robustness:
  - Assert `reset` low asynchronously mid-DRAIN → all outputs go to reset values immediately.
  - Next `start` after `reset` release runs a clean job.
  - `start` pulses while `busy`=1 are ignored.

Source files
------------

// File: rtl/l0_loader.sv
// ---------------------------------------------------------------------------
// l0_loader
//
// Sequencing controller for the L0 input buffer. On `start` it reads `len`
// activation vectors from the activation SRAM into the L0 FIFO bank. It then
// issues `len` read requests toward the systolic array, gated by `ex_en`.
// Next it waits `row` cycles so the internally staggered last row can pop.
// Finally it pulses `done`. No data passes through this block: SRAM Q is
// wired straight to the L0 write port, and this block only sequences
// control.
//
// Parameters
//   row     number of L0 rows (FIFOs); sets the flush length
//   depth   L0 FIFO depth; the job length saturates to this value
//   addr_w  SRAM address width
//   len_w   width of `len` (must be able to hold `depth`)
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a job (accepted only in IDLE)
//   base_addr  in   first SRAM address, latched with start
//   len        in   number of vectors, latched with start
//   ex_en      in   array can accept a vector this cycle (DRAIN only)
//   l0_full    in   OR of the L0 FIFO full flags
//   sram_cen   out  SRAM chip enable, active-low
//   sram_wen   out  SRAM write enable, active-low, held high (read-only)
//   sram_addr  out  SRAM read address
//   l0_wr      out  L0 write strobe, aligned with SRAM read data
//   l0_rd      out  L0 row-0 read request
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   err        out  sticky overflow flag (write while full)
// ---------------------------------------------------------------------------
module l0_loader #(
  parameter int row    = 8,
  parameter int depth  = 64,
  parameter int addr_w = 11,
  parameter int len_w  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [len_w-1:0]  len,
  input  logic              ex_en,
  input  logic              l0_full,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int fcnt_w = (row > 1) ? $clog2(row) : 1;
  localparam logic [len_w-1:0]  depth_c    = len_w'(depth);
  localparam logic [fcnt_w-1:0] flush_last = fcnt_w'(row - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LWAIT,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

  state_t              state;
  logic [len_w-1:0]    n_r;      // effective job length, latched at start
  logic [len_w-1:0]    cnt;      // reads issued in LOAD, pulses issued in DRAIN
  logic [addr_w-1:0]   rd_addr;  // next SRAM address to issue
  logic [fcnt_w-1:0]   fcnt;     // flush down-counter
  logic [len_w-1:0]    len_eff;
  logic                cnt_last;

  // Clamp the requested length to what one FIFO can hold.
  function automatic logic [len_w-1:0] sat_len(input logic [len_w-1:0] l);
    return (l > depth_c) ? depth_c : l;
  endfunction

  always_comb begin
    len_eff  = sat_len(len);
    cnt_last = (cnt == (n_r - len_w'(1)));
  end

  // All outputs are registered from the state seen at the edge, so each
  // output trails the state it describes by one cycle. l0_wr is the
  // one-cycle-delayed SRAM read issue, matching the SRAM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_r       <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      fcnt      <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      l0_wr     <= 1'b0;
      l0_rd     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sram_wen <= 1'b1;
      l0_wr    <= ~sram_cen;
      err      <= err | (l0_wr & l0_full);
      busy     <= (state != IDLE);
      done     <= (state == DONE);
      sram_cen <= 1'b1;
      l0_rd    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= base_addr;
            n_r     <= len_eff;
            cnt     <= '0;
            state   <= (len_eff != '0) ? LOAD : DONE;
          end
        end

        LOAD: begin
          sram_cen  <= 1'b0;
          sram_addr <= rd_addr;
          rd_addr   <= rd_addr + addr_w'(1);  // wraps modulo 2^addr_w
          cnt       <= cnt + len_w'(1);
          if (cnt_last) begin
            state <= LWAIT;
          end
        end

        // The last SRAM read's data is written into L0 during this cycle.
        LWAIT: begin
          cnt   <= '0;
          state <= DRAIN;
        end

        DRAIN: begin
          if (ex_en) begin
            l0_rd <= 1'b1;
            cnt   <= cnt + len_w'(1);
            if (cnt_last) begin
              fcnt  <= flush_last;
              state <= FLUSH;
            end
          end
        end

        // The read request ripples one row per cycle inside L0. Wait
        // until the last row has popped its final entry.
        FLUSH: begin
          fcnt <= fcnt - fcnt_w'(1);
          if (fcnt == '0) begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
